// File: rtl/player_motion_ctrl_if.sv
// Bundle between the keyboard/collision front end and the player motion engine.
// The sprite renderer and detection modules read the position and status outputs.
interface player_motion_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int V_W = 6
);
    logic                  restart;
    logic                  enable;
    logic                  key_left;
    logic                  key_right;
    logic                  key_jump;
    logic                  coll_down;
    logic                  coll_up;
    logic                  coll_left;
    logic                  coll_right;
    logic [X_W-1:0]        x_pos;
    logic [Y_W-1:0]        y_pos;
    logic signed [V_W-1:0] vspeed;
    logic                  facing;
    logic                  airborne;
    logic                  moving;
    logic                  tick;
    logic                  fell_out;

    modport master (
        output restart, enable, key_left, key_right, key_jump,
               coll_down, coll_up, coll_left, coll_right,
        input  x_pos, y_pos, vspeed, facing, airborne, moving, tick, fell_out
    );

    modport slave (
        input  restart, enable, key_left, key_right, key_jump,
               coll_down, coll_up, coll_left, coll_right,
        output x_pos, y_pos, vspeed, facing, airborne, moving, tick, fell_out
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player movement engine: walking, jump/gravity, collision response and screen clamps,
// all advanced once per physics tick derived from the system clock.
module player_motion_ctrl #(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int V_W        = 6,
    parameter int TICK_DIV   = 100000,
    parameter int X_INIT     = 250,
    parameter int Y_INIT     = 250,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 504,
    parameter int Y_MAX      = 360,
    parameter int H_STEP     = 1,
    parameter int GRAVITY    = 2,
    parameter int JUMP_SPEED = 4,
    parameter int V_MAX      = 8
) (
    input  logic                clk,
    input  logic                rstn,
    player_motion_ctrl_if.slave bus
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int XS    = X_W + 2;
    localparam int YS    = Y_W + 2;
    localparam int VS    = V_W + 1;
    localparam logic signed [V_W-1:0] V_JUMP = V_W'(-JUMP_SPEED);

    typedef enum logic [1:0] {GROUND, RISING, FALLING, HALT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] v_q, v_d;
    logic                  facing_q, facing_d;
    logic                  moving_q, moving_d;
    logic                  armed_q, armed_d;
    logic                  fell_q, fell_d;
    logic                  tick_q;
    logic                  wrap, step;
    logic signed [XS-1:0]  x_dec, x_inc;
    logic signed [YS-1:0]  y_sum;
    logic signed [VS-1:0]  v_grav;

    assign wrap   = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign step   = wrap && bus.enable;
    // Sums are one or two bits wider than the operands so clamping sees the true value.
    assign x_dec  = signed'(XS'(x_q)) - XS'(H_STEP);
    assign x_inc  = signed'(XS'(x_q)) + XS'(H_STEP);
    assign y_sum  = signed'(YS'(y_q)) + YS'(v_q);
    assign v_grav = VS'(v_q) + VS'(GRAVITY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || bus.restart) begin
            state_q  <= FALLING;
            cnt_q    <= '0;
            x_q      <= X_W'(X_INIT);
            y_q      <= Y_W'(Y_INIT);
            v_q      <= '0;
            facing_q <= 1'b1;
            moving_q <= 1'b0;
            armed_q  <= 1'b1;
            fell_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= wrap ? '0 : cnt_q + 1'b1;
            x_q      <= x_d;
            y_q      <= y_d;
            v_q      <= v_d;
            facing_q <= facing_d;
            moving_q <= moving_d;
            armed_q  <= armed_d;
            fell_q   <= fell_d;
            tick_q   <= wrap;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        v_d      = v_q;
        facing_d = facing_q;
        moving_d = moving_q;
        armed_d  = armed_q;
        fell_d   = 1'b0;
        if (step) begin
            if (!bus.key_jump) armed_d = 1'b1;
            if (state_q == HALT) begin
                moving_d = 1'b0;
            end else if (bus.key_left && !bus.key_right) begin
                facing_d = 1'b0;
                moving_d = 1'b1;
                if (!bus.coll_left)
                    x_d = (x_dec < XS'(X_MIN)) ? X_W'(X_MIN) : X_W'(x_dec);
            end else if (bus.key_right && !bus.key_left) begin
                facing_d = 1'b1;
                moving_d = 1'b1;
                if (!bus.coll_right)
                    x_d = (x_inc > XS'(X_MAX)) ? X_W'(X_MAX) : X_W'(x_inc);
            end else begin
                moving_d = 1'b0;
            end

            case (state_q)
                GROUND: begin
                    v_d = '0;
                    if (bus.key_jump && armed_q) begin
                        v_d     = V_JUMP;
                        armed_d = 1'b0;
                        state_d = RISING;
                    end else if (!bus.coll_down) begin
                        state_d = FALLING;
                    end
                end
                RISING: begin
                    if (bus.coll_up || y_sum[YS-1]) begin
                        if (!bus.coll_up) y_d = '0;
                        v_d     = '0;
                        state_d = FALLING;
                    end else begin
                        y_d = Y_W'(y_sum);
                        v_d = V_W'(v_grav);
                        if (!v_grav[VS-1]) state_d = FALLING;
                    end
                end
                FALLING: begin
                    if (bus.coll_down) begin
                        v_d     = '0;
                        state_d = GROUND;
                    end else begin
                        v_d = (v_grav > VS'(V_MAX)) ? V_W'(V_MAX) : V_W'(v_grav);
                        if (y_sum >= YS'(Y_MAX)) begin
                            y_d     = Y_W'(Y_MAX);
                            fell_d  = 1'b1;
                            state_d = HALT;
                        end else if (y_sum[YS-1]) begin
                            y_d = '0;
                        end else begin
                            y_d = Y_W'(y_sum);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.x_pos    = x_q;
        bus.y_pos    = y_q;
        bus.vspeed   = v_q;
        bus.facing   = facing_q;
        bus.moving   = moving_q;
        bus.tick     = tick_q;
        bus.fell_out = fell_q;
        bus.airborne = (state_q == RISING) || (state_q == FALLING);
    end
endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Parametrised player-movement engine: horizontal walking, jump/gravity physics, ceiling/floor/wall response and screen clamping, all on an internal game tick.
- Sits between the keyboard decoder (WASD levels) plus the combined per-block collision flags, and the sprite renderer and detection modules (x/y position, facing, airborne, moving).
- Adds over the current inline logic: signed saturating vertical speed, an explicit state machine, jump re-arm, screen clamps, a pit/fall-out event, and enable/restart control.

Parameters:
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- V_W, 6, signed vertical speed width
- TICK_DIV, 100000, clk cycles per physics tick (1 ms at 100 MHz); must be >= 2
- X_INIT, 250, x after reset/restart
- Y_INIT, 250, y after reset/restart
- X_MIN, 0, leftmost legal x
- X_MAX, 504, rightmost legal x (551 - 47 sprite width)
- Y_MAX, 360, lowest legal y; reaching it while falling is a fall-out
- H_STEP, 1, pixels moved per tick horizontally
- GRAVITY, 2, speed added per airborne tick
- JUMP_SPEED, 4, initial upward speed magnitude
- V_MAX, 8, terminal downward speed

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- restart  in  1  synchronous restart to initial state, level
- enable  in  1  game running; when 0, ticks are ignored
- key_left, key_right, key_jump  in  1 each  held-key levels
- coll_down, coll_up, coll_left, coll_right  in  1 each  OR-combined collision flags for the current position
- x_pos  out  X_W  player x
- y_pos  out  Y_W  player y
- vspeed  out  V_W  signed vertical speed; negative means up
- facing  out  1  0 = left, 1 = right
- airborne  out  1  1 when state is RISING or FALLING
- moving  out  1  1 if the last tick had exactly one of left/right held
- tick  out  1  one-clk pulse per physics tick
- fell_out  out  1  one-clk pulse on pit fall

Behaviour:
- Reset (rstn = 0, async):
  - x_pos = X_INIT, y_pos = Y_INIT, vspeed = 0.
  - state = FALLING, facing = 1, moving = 0, tick = 0, fell_out = 0.
  - jump_armed = 1, tick counter = 0.
- Tick counter counts 0 .. TICK_DIV-1 continuously. tick pulses on the clk where the count wraps to 0. All physics updates are registered on that same edge, so outputs change 1 clk after the wrap.
- restart = 1 has priority over tick:
  - Applies the reset values on the next clk and clears the tick counter.
  - fell_out is not generated that cycle.
- enable = 0: tick still pulses, but state, position, speed, facing and moving all hold.
- Horizontal, every enabled tick, in every state except HALT:
  - Left only: facing = 0, moving = 1; x -= H_STEP unless coll_left, clamped at X_MIN.
  - Right only: facing = 1, moving = 1; x += H_STEP unless coll_right, clamped at X_MAX.
  - Both or neither: moving = 0, x and facing unchanged.
- jump_armed: set on any tick where key_jump = 0; cleared when a jump starts. Holding jump therefore never auto-repeats.
- State machine, evaluated per enabled tick, using registered values from before the tick:
  - GROUND:
    - vspeed = 0, y unchanged.
    - If key_jump & jump_armed: vspeed = -JUMP_SPEED, go to RISING. Jump has priority over losing the floor.
    - Else if !coll_down: go to FALLING with vspeed 0.
  - RISING:
    - If coll_up, or y + vspeed < 0: y = max(y + vspeed, 0) only when there is no coll_up (y unchanged on coll_up); vspeed = 0; go to FALLING.
    - Else: y += vspeed, vspeed += GRAVITY. If the new vspeed >= 0, go to FALLING.
  - FALLING:
    - If coll_down: go to GROUND, vspeed = 0, y unchanged.
    - Else: y = min(y + vspeed, Y_MAX), vspeed = min(vspeed + GRAVITY, V_MAX).
    - If y reaches Y_MAX: pulse fell_out, go to HALT.
  - HALT: nothing moves, moving = 0; only restart or reset leaves it.
- Arithmetic: signed V_W-bit; sums formed one bit wider before clamping, so no wrap-around. y never leaves [0, Y_MAX] and x never leaves [X_MIN, X_MAX].
- Simultaneous coll_left and key_left: no motion, but facing and moving still update.

Test Plan (TICK_DIV = 4 unless stated):
- Reset, then hold idle with coll_down = 1 -> tick every 4 clks; after the first tick state GROUND, x = 250, y = 250, airborne = 0.
- On ground, hold key_left for 260 ticks -> x decrements by 1 per tick down to 0 and stays at 0; facing = 0, moving = 1; hold left+right -> moving = 0, x holds.
- Jump from y = 250 with coll_down dropped after takeoff, coll_down = 1 when y = 250 again:
  - (y, vspeed) per tick: (250, -4), (246, -2), (244, 0, FALLING), (244, 2), (246, 4), (250, 6), then GROUND with vspeed 0.
  - Key held throughout -> no second jump until key_jump is released for one tick.
- Rising with coll_up asserted at vspeed = -4 -> vspeed = 0, FALLING, y unchanged.
- Fall with no floor from y = 340 -> vspeed saturates at 8; y clamps at 360; fell_out pulses for exactly 1 clk; HALT ignores keys; restart -> x = 250, y = 250.
- enable = 0 for 10 ticks mid-jump -> all outputs frozen. Assert rstn low mid-clk -> outputs reset immediately, asynchronously.
